// File: rtl/divider_pkg.sv
// Shared types and default widths for the sequential restoring divider.

package divider_pkg;

    localparam int unsigned DIV_DW_DEF = 4;
    localparam int unsigned DIV_VW_DEF = 2;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } div_state_e;

endpackage

// File: rtl/divider_step.sv
// One restoring-division step: bring in the next dividend bit, subtract the divisor if it fits.

module divider_step #(
    parameter int unsigned VW = 2
) (
    input  logic [VW-1:0] partial_in,
    input  logic          dividend_bit,
    input  logic [VW-1:0] divisor,
    output logic [VW-1:0] partial_out,
    output logic          quotient_bit
);

    // The trial value needs one extra bit; the stored partial never does because it is < divisor.
    logic [VW:0] trial;

    always_comb begin
        trial        = {partial_in, dividend_bit};
        quotient_bit = (trial >= {1'b0, divisor});
        partial_out  = quotient_bit ? VW'(trial - {1'b0, divisor}) : trial[VW-1:0];
    end

endmodule

// File: rtl/divider_seq.sv
// Sequential restoring divider, one quotient bit per clock with start/busy/done handshake.
// Optional DIVIDER_ZERO_CHECK_EN short-circuits a zero divisor straight to DONE with dz set.

module divider_seq
    import divider_pkg::*;
#(
    parameter int unsigned DW = DIV_DW_DEF,
    parameter int unsigned VW = DIV_VW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          busy,
    output logic          done,
    output logic          dz
);

    localparam int unsigned CW = $clog2(DW + 1);

    div_state_e    state_q, state_d;
    logic [DW-1:0] dividend_q, dividend_d;
    logic [VW-1:0] divisor_q, divisor_d;
    logic [VW-1:0] partial_q, partial_d;
    logic [DW-1:0] quo_sr_q, quo_sr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] quotient_q, quotient_d;
    logic [VW-1:0] remainder_q, remainder_d;
    logic          dz_q, dz_d;

    logic [VW-1:0] step_partial;
    logic          step_bit;

    divider_step #(
        .VW(VW)
    ) u_step (
        .partial_in   (partial_q),
        .dividend_bit (dividend_q[DW-1]),
        .divisor      (divisor_q),
        .partial_out  (step_partial),
        .quotient_bit (step_bit)
    );

    always_comb begin
        state_d     = state_q;
        dividend_d  = dividend_q;
        divisor_d   = divisor_q;
        partial_d   = partial_q;
        quo_sr_d    = quo_sr_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dz_d        = dz_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    dividend_d = dividend;
                    divisor_d  = divisor;
                    partial_d  = '0;
                    quo_sr_d   = '0;
                    cnt_d      = CW'(DW);
                    dz_d       = 1'b0;
                    state_d    = StRun;
`ifdef DIVIDER_ZERO_CHECK_EN
                    if (divisor == '0) begin
                        state_d     = StDone;
                        dz_d        = 1'b1;
                        quotient_d  = '1;
                        remainder_d = dividend[VW-1:0];
                    end
`endif
                end
            end
            StRun: begin
                dividend_d = dividend_q << 1;
                partial_d  = step_partial;
                quo_sr_d   = (quo_sr_q << 1) | DW'(step_bit);
                cnt_d      = cnt_q - CW'(1);
                // Results are published on the edge that performs the final step.
                if (cnt_q == CW'(1)) begin
                    state_d     = StDone;
                    quotient_d  = quo_sr_d;
                    remainder_d = step_partial;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            dividend_q  <= '0;
            divisor_q   <= '0;
            partial_q   <= '0;
            quo_sr_q    <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dz_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            dividend_q  <= dividend_d;
            divisor_q   <= divisor_d;
            partial_q   <= partial_d;
            quo_sr_q    <= quo_sr_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dz_q        <= dz_d;
        end
    end

    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign busy      = (state_q == StRun);
    assign done      = (state_q == StDone);
    assign dz        = dz_q;

endmodule

// File: tb/tb_divider_seq.sv
// Self-checking bench for divider_seq against an arithmetic reference model.

module tb_divider_seq;

    localparam int DW = 4;
    localparam int VW = 2;
`ifdef DIVIDER_ZERO_CHECK_EN
    localparam bit ZC = 1'b1;
`else
    localparam bit ZC = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [DW-1:0] dividend = '0;
    logic [VW-1:0] divisor = '0;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          busy;
    logic          done;
    logic          dz;

    int n_cmp = 0;
    int n_fail = 0;

    divider_seq #(
        .DW(DW),
        .VW(VW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .done      (done),
        .dz        (dz)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    // {quotient, remainder, dz} expected for a/b.
    function automatic logic [6:0] model(input int a, input int b);
        int q;
        int r;
        bit z;
        if (b == 0) begin
            q = (1 << DW) - 1;
            r = a % (1 << VW);
            z = ZC;
        end else begin
            q = a / b;
            r = a % b;
            z = 1'b0;
        end
        return {q[3:0], r[1:0], z};
    endfunction

    function automatic int exp_done_at(input int b);
        return (ZC && b == 0) ? 1 : DW + 1;
    endfunction

    function automatic int exp_busy(input int b);
        return (ZC && b == 0) ? 0 : DW;
    endfunction

    // Launch one operation and observe it; operands are scrambled after the load edge.
    task automatic run_op(input logic [3:0] a, input logic [1:0] b, output int busy_n,
                          output int done_at, output int done_n, output logic [6:0] res);
        busy_n = 0;
        done_at = -1;
        done_n = 0;
        res = '0;
        @(negedge clk);
        dividend = a;
        divisor = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= DW + 3; k++) begin
            if (busy) busy_n++;
            if (busy && done) busy_n += 100;
            if (done) begin
                done_n++;
                if (done_at < 0) begin
                    done_at = k;
                    res = {quotient, remainder, dz};
                end
            end
            dividend = 4'($urandom);
            divisor = 2'($urandom);
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({quotient, remainder, busy, done, dz} !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want 0", {quotient, remainder, busy, done, dz});
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [3:0] a_tab [3] = '{4'd9, 4'd2, 4'd15};
        logic [1:0] b_tab [3] = '{2'd2, 2'd3, 2'd1};
        logic [6:0] want_tab [3] = '{{4'd4, 2'd1, 1'b0}, {4'd0, 2'd2, 1'b0}, {4'd15, 2'd0, 1'b0}};
        int busy_n, done_at, done_n;
        logic [6:0] res;
        for (int i = 0; i < 3; i++) begin
            run_op(a_tab[i], b_tab[i], busy_n, done_at, done_n, res);
            n_cmp++;
            if (res !== want_tab[i]) begin
                n_fail++;
                $display("FAIL directed_%0d result: got %h want %h", i, res, want_tab[i]);
            end
            n_cmp++;
            if (done_at != DW + 1) begin
                n_fail++;
                $display("FAIL directed_%0d done_at: got %0d want %0d", i, done_at, DW + 1);
            end
            n_cmp++;
            if (busy_n != DW || done_n != 1) begin
                n_fail++;
                $display("FAIL directed_%0d busy/done counts: got %0d/%0d want %0d/1",
                         i, busy_n, done_n, DW);
            end
        end
    endtask

    task automatic test_roundtrip();
        int busy_n, done_at, done_n;
        logic [6:0] res;
        for (int a = 0; a < 4; a++) begin
            for (int b = 1; b < 4; b++) begin
                run_op(4'(a * b), 2'(b), busy_n, done_at, done_n, res);
                n_cmp++;
                if (res !== {4'(a), 2'd0, 1'b0} || done_n != 1) begin
                    n_fail++;
                    $display("FAIL roundtrip %0d*%0d: got %h (done %0d) want %h",
                             a, b, res, done_n, {4'(a), 2'd0, 1'b0});
                end
            end
        end
    endtask

    task automatic test_random();
        int busy_n, done_at, done_n;
        logic [6:0] res;
        logic [3:0] a;
        logic [1:0] b;
        for (int i = 0; i < 24; i++) begin
            a = 4'($urandom);
            b = 2'($urandom);
            run_op(a, b, busy_n, done_at, done_n, res);
            n_cmp++;
            if (res !== model(a, b) || done_at != exp_done_at(b) || busy_n != exp_busy(b)
                || done_n != 1) begin
                n_fail++;
                $display("FAIL random %0d/%0d: got res %h at %0d busy %0d n %0d want %h at %0d busy %0d",
                         a, b, res, done_at, busy_n, done_n, model(a, b), exp_done_at(b),
                         exp_busy(b));
            end
        end
    endtask

    task automatic test_div_zero();
        int busy_n, done_at, done_n;
        logic [6:0] res;
        run_op(4'd9, 2'd0, busy_n, done_at, done_n, res);
        n_cmp++;
        if (res !== {4'd15, 2'd1, ZC}) begin
            n_fail++;
            $display("FAIL div_zero result: got %h want %h", res, {4'd15, 2'd1, ZC});
        end
        n_cmp++;
        if (done_at != exp_done_at(0) || busy_n != exp_busy(0) || done_n != 1) begin
            n_fail++;
            $display("FAIL div_zero timing: got at %0d busy %0d n %0d want at %0d busy %0d n 1",
                     done_at, busy_n, done_n, exp_done_at(0), exp_busy(0));
        end
        run_op(4'd9, 2'd2, busy_n, done_at, done_n, res);
        n_cmp++;
        if (res !== {4'd4, 2'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL div_zero_clear: got %h want %h", res, {4'd4, 2'd1, 1'b0});
        end
    endtask

    task automatic test_ignore_start();
        int busy_n = 0;
        int done_n = 0;
        int done_at = -1;
        logic [6:0] res = '0;
        @(negedge clk);
        dividend = 4'd9;
        divisor = 2'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= DW + 5; k++) begin
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (done_at < 0) begin
                    done_at = k;
                    res = {quotient, remainder, dz};
                end
            end
            if (k == 2) begin
                start = 1'b1;
                dividend = 4'd15;
                divisor = 2'd1;
            end else if (k == DW + 1) begin
                start = 1'b1;
                dividend = 4'd7;
                divisor = 2'd3;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        n_cmp++;
        if (res !== {4'd4, 2'd1, 1'b0} || done_at != DW + 1) begin
            n_fail++;
            $display("FAIL ignore_start result: got %h at %0d want %h at %0d",
                     res, done_at, {4'd4, 2'd1, 1'b0}, DW + 1);
        end
        n_cmp++;
        if (busy_n != DW || done_n != 1) begin
            n_fail++;
            $display("FAIL ignore_start counts: got busy %0d done %0d want %0d/1",
                     busy_n, done_n, DW);
        end
        n_cmp++;
        if ({quotient, remainder} !== {4'd4, 2'd1}) begin
            n_fail++;
            $display("FAIL result_hold: got %h want %h", {quotient, remainder}, {4'd4, 2'd1});
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] a;
        logic [1:0] b;
        logic [6:0] expq[$];
        logic [6:0] want;
        int last = -1;
        int busy_n = 0;
        int ops = 0;
        a = 4'($urandom);
        b = 2'($urandom_range(1, 3));
        @(negedge clk);
        dividend = a;
        divisor = b;
        start = 1'b1;
        expq.push_back(model(a, b));
        for (int k = 1; k <= 60 && ops < 5; k++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (done) begin
                ops++;
                want = (expq.size() > 0) ? expq.pop_front() : 7'h7f;
                n_cmp++;
                if ({quotient, remainder, dz} !== want || busy_n != DW) begin
                    n_fail++;
                    $display("FAIL b2b op %0d: got %h busy %0d want %h busy %0d",
                             ops, {quotient, remainder, dz}, busy_n, want, DW);
                end
                if (last >= 0) begin
                    n_cmp++;
                    if (k - last != DW + 2) begin
                        n_fail++;
                        $display("FAIL b2b spacing: got %0d want %0d", k - last, DW + 2);
                    end
                end
                last = k;
                busy_n = 0;
                a = 4'($urandom);
                b = 2'($urandom_range(1, 3));
                dividend = a;
                divisor = b;
                expq.push_back(model(a, b));
            end
        end
        start = 1'b0;
        n_cmp++;
        if (ops != 5) begin
            n_fail++;
            $display("FAIL b2b op_count: got %0d want 5", ops);
        end
        repeat (DW + 3) @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int busy_n, done_at, done_n;
        logic [6:0] res;
        int stray = 0;
        @(negedge clk);
        dividend = 4'd13;
        divisor = 2'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({quotient, remainder, busy, done, dz} !== 9'd0) begin
            n_fail++;
            $display("FAIL mid_reset outputs: got %b want 0", {quotient, remainder, busy, done, dz});
        end
        rst = 1'b0;
        for (int k = 0; k < DW + 3; k++) begin
            if (done || busy) stray++;
            @(negedge clk);
        end
        n_cmp++;
        if (stray != 0) begin
            n_fail++;
            $display("FAIL mid_reset stray activity: got %0d cycles want 0", stray);
        end
        run_op(4'd13, 2'd3, busy_n, done_at, done_n, res);
        n_cmp++;
        if (res !== {4'd4, 2'd1, 1'b0} || done_at != DW + 1 || done_n != 1) begin
            n_fail++;
            $display("FAIL after_reset op: got %h at %0d n %0d want %h at %0d n 1",
                     res, done_at, done_n, {4'd4, 2'd1, 1'b0}, DW + 1);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_roundtrip();
        test_div_zero();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
